// File: rtl/wb_rr_interconnect.sv
// wb_rr_interconnect: Wishbone classic shared bus with round-robin master arbitration,
// base/mask slave decode, decode-error and timeout error responses.
module wb_rr_interconnect #(
    parameter int N_MST = 3,
    parameter int N_SLV = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {4{32'hFFFF_F000}},
    parameter int TIMEOUT = 255,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_MST-1:0]      mst_cyc_i,
    input  logic [N_MST-1:0]      mst_stb_i,
    input  logic [N_MST-1:0]      mst_we_i,
    input  logic [N_MST*AW-1:0]   mst_addr_i,
    input  logic [N_MST*DW-1:0]   mst_wdata_i,
    input  logic [N_MST*DW/8-1:0] mst_sel_i,
    output logic [N_MST*DW-1:0]   mst_rdata_o,
    output logic [N_MST-1:0]      mst_ack_o,
    output logic [N_MST-1:0]      mst_err_o,
    output logic [N_SLV-1:0]      slv_cyc_o,
    output logic [N_SLV-1:0]      slv_stb_o,
    output logic [N_SLV-1:0]      slv_we_o,
    output logic [N_SLV*AW-1:0]   slv_addr_o,
    output logic [N_SLV*DW-1:0]   slv_wdata_o,
    output logic [N_SLV*DW/8-1:0] slv_sel_o,
    input  logic [N_SLV*DW-1:0]   slv_rdata_i,
    input  logic [N_SLV-1:0]      slv_ack_i,
    output logic                  err_valid_o,
    output logic [AW-1:0]         err_addr_o
);
    localparam int GW = N_MST > 1 ? $clog2(N_MST) : 1;
    localparam int SW = N_SLV > 1 ? $clog2(N_SLV) : 1;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_n;
    logic [GW-1:0] grant, rr_ptr, arb;
    logic [SW-1:0] hit;
    logic [31:0] tcnt;
    logic hit_any, active, fwd, abort, ack_hit, miss, tmo, done, err;
    logic g_cyc, g_stb, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [DW/8-1:0] g_sel;
    logic [N_MST-1:0] req;
    assign req     = mst_cyc_i & mst_stb_i;
    assign g_cyc   = mst_cyc_i[grant];
    assign g_stb   = mst_stb_i[grant];
    assign g_we    = mst_we_i[grant];
    assign g_addr  = mst_addr_i[int'(grant)*AW +: AW];
    assign g_wdata = mst_wdata_i[int'(grant)*DW +: DW];
    assign g_sel   = mst_sel_i[int'(grant)*(DW/8) +: DW/8];
    // Reset masks the whole datapath so no ack can escape in the reset cycle
    assign active  = state == ACTIVE && !rst;
    assign abort   = active && !g_cyc;
    assign fwd     = active && g_cyc && hit_any;
    assign ack_hit = fwd && slv_ack_i[hit];
    assign miss    = active && g_cyc && !hit_any;
    assign tmo     = TIMEOUT != 0 && fwd && !slv_ack_i[hit] && tcnt == 32'(TIMEOUT - 1);
    assign done    = ack_hit || miss || tmo;
    assign err     = miss || tmo;
    // Descending scans so the lowest rotation offset / lowest slave index wins
    always_comb begin
        arb = rr_ptr;
        for (int i = N_MST - 1; i >= 0; i--)
            if (req[(int'(rr_ptr) + i) % N_MST]) arb = GW'((int'(rr_ptr) + i) % N_MST);
    end
    always_comb begin
        hit = '0;
        hit_any = 1'b0;
        for (int s = N_SLV - 1; s >= 0; s--)
            if ((g_addr & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]) begin
                hit = SW'(s);
                hit_any = 1'b1;
            end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
            tcnt <= '0;
            err_valid_o <= 1'b0;
            err_addr_o <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req != '0) begin
                grant <= arb;
                tcnt <= '0;
            end
            if (active) tcnt <= tcnt + 32'd1;
            if (done || abort) rr_ptr <= (int'(grant) == N_MST - 1) ? '0 : grant + GW'(1);
            if (err) begin
                err_valid_o <= 1'b1;
                err_addr_o <= g_addr;
            end
        end
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && req != '0) state_n = ACTIVE;
        if (done || abort) state_n = IDLE;
    end
    always_comb begin
        slv_cyc_o = '0;
        slv_stb_o = '0;
        slv_we_o = '0;
        if (fwd) begin
            slv_cyc_o[hit] = 1'b1;
            slv_stb_o[hit] = g_stb;
            slv_we_o[hit] = g_we;
        end
        slv_addr_o = active ? {N_SLV{g_addr}} : '0;
        slv_wdata_o = active ? {N_SLV{g_wdata}} : '0;
        slv_sel_o = active ? {N_SLV{g_sel}} : '0;
        mst_ack_o = '0;
        mst_err_o = '0;
        mst_rdata_o = '0;
        if (done) begin
            mst_ack_o[grant] = 1'b1;
            mst_err_o[grant] = err;
            mst_rdata_o[int'(grant)*DW +: DW] = err ? ERR_DATA : slv_rdata_i[int'(hit)*DW +: DW];
        end
    end
endmodule
